dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter LOCK_MAX, default 8, meaning the maximum consecutive granted cycles one locked master may hold DMEM.
REQ-002 SHALL have parameter AW, default 32, meaning the address width.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port clk, input, 1, the system clock.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have ports m0_req / m1_req, input, 1 each, access request (m0 = core LSU, m1 = DMA/debug).
REQ-007 SHALL have ports m0_we / m1_we, input, 1 each, 1 = store, 0 = load.
REQ-008 SHALL have ports m0_lock / m1_lock, input, 1 each, request to keep ownership (read-modify-write).
REQ-009 SHALL have ports m0_addr / m1_addr, input, AW each, byte address.
REQ-010 SHALL have ports m0_wdata / m1_wdata, input, 32 each, store data.
REQ-011 SHALL have ports m0_gnt / m1_gnt, output, 1 each, access accepted this cycle.
REQ-012 SHALL have ports m0_rvalid / m1_rvalid, output, 1 each, load data valid.
REQ-013 SHALL have ports m0_rdata / m1_rdata, output, 32 each, load data.
REQ-014 SHALL have ports mem_addr (AW), mem_wdata (32), mem_write (1) and mem_read (1), all outputs, the DMEM command.
REQ-015 SHALL have port mem_rdata, input, 32, combinational DMEM read data.

Function
REQ-016 SHALL implement a state machine with states ARB, LOCK0 and LOCK1.
REQ-017 In ARB, exactly one requesting master SHALL be granted per cycle, selected by a 1-bit round-robin pointer (ptr=0 favours m0).
REQ-018 When only one master requests in ARB, that master SHALL be granted regardless of ptr.
REQ-019 After each ARB grant to master i, ptr SHALL point to the other master.
REQ-020 gnt SHALL be combinational in the request cycle.
REQ-021 mem_* SHALL carry the granted master's addr/wdata.
REQ-022 mem_write SHALL equal gnt&we and mem_read SHALL equal gnt&~we.
REQ-023 When no master is granted, mem_write, mem_read, mem_addr and mem_wdata SHALL all be 0.
REQ-024 A store SHALL commit at the clock edge ending its grant cycle.
REQ-025 Load latency SHALL be 1: mem_rdata is registered at the grant-cycle edge, and rdata_i/rvalid_i are presented the following cycle for exactly one cycle.
REQ-026 rdata_i SHALL hold its last value when rvalid_i=0.
REQ-027 A granted master with lock=1 in ARB SHALL move the FSM to LOCKi and load the lock counter with 1.
REQ-028 In LOCKi, only master i SHALL be grantable; the other master's req is stalled (gnt=0).
REQ-029 In LOCKi, the counter SHALL increment on each granted cycle.
REQ-030 LOCKi SHALL return to ARB, with ptr set to favour the other master, when master i has req=1 and lock=0 (this cycle is still granted) or req=0.
REQ-031 LOCKi SHALL also return to ARB when the counter reaches LOCK_MAX; this is a forced release, and the cycle that reaches LOCK_MAX is still granted.
REQ-032 After a forced release, lock SHALL be ignored until master i deasserts lock for one cycle.
REQ-033 Simultaneous load grant and pending rvalid SHALL be supported back-to-back (one access per cycle, full throughput).
REQ-034 The arbiter SHALL NOT check address alignment; mem_addr is a pass-through.

Reset
REQ-035 On rst=1, and asynchronously mid-operation, the block SHALL set: state=ARB, ptr=0, lock counter=0, sticky-ignore flags=0, both rvalid=0, both rdata=0.
REQ-036 gnt and mem_* SHALL be 0 while rst=1.
REQ-037 A load granted in the cycle in which reset asserts SHALL produce no rvalid.

Structure
REQ-038 Shared package dmem_arb_pkg SHALL hold the state enum (ARB/LOCK0/LOCK1) and the master-ID width constant.
REQ-039 No sub-module SHALL be used; DMEM is instantiated by the parent, and the lock counter is $clog2(LOCK_MAX+1) bits.

Verification
REQ-040 Scenario: after reset, both masters load simultaneously -> m0 granted cycle 1 and m1 cycle 2; rvalid follows each grant by 1 cycle with the correct words.
REQ-041 Scenario: m1 stores 0xDEADBEEF @0x40 while m0 is idle, then m0 loads @0x40 -> m0_rdata=0xDEADBEEF, m0_rvalid one cycle after grant.
REQ-042 Scenario: both masters request continuously for 10 cycles -> grants strictly alternate, with 5 to each master.
REQ-043 Scenario: m0 locks for a 3-cycle RMW while m1 requests -> m1_gnt=0 for those 3 cycles and is granted on the next cycle.
REQ-044 Scenario: m0 holds lock with LOCK_MAX=8 -> forced release after 8 grants, m1 granted next cycle, and m0's lock ignored until it drops.
REQ-045 Scenario: rst asserted mid-lock with a load in flight -> state=ARB, rvalid=0, and the next dual request grants m0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types for the two-master DMEM arbiter: FSM state encoding and master-ID width.
package dmem_arb_pkg;

  localparam int MID_W = 1;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-master DMEM arbiter: round-robin grant, bounded lock ownership for RMW, 1-cycle load return.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int LOCK_MAX = 8,
  parameter int AW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic          m0_we,
  input  logic          m1_we,
  input  logic          m0_lock,
  input  logic          m1_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [31:0]   m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [31:0]   m0_rdata,
  output logic [31:0]   m1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [31:0]   mem_rdata
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  arb_state_e       state_r, state_s;
  logic [MID_W-1:0] ptr_r, ptr_s;
  logic [CW-1:0]    cnt_r, cnt_s, cnt_inc_s;
  logic [1:0]       ign_r, ign_s;
  logic [1:0]       lk_s;
  logic [1:0]       gnt_s;
  logic [1:0]       rvalid_r;
  logic [31:0]      rdata0_r, rdata1_r;

  // A master whose lock was forcibly released has its lock masked until it drops it.
  assign lk_s      = {m1_lock & ~ign_r[1], m0_lock & ~ign_r[0]};
  assign cnt_inc_s = cnt_r + CW'(1);

  // Grant selection and next-state computation.
  always_comb begin
    gnt_s   = 2'b00;
    state_s = state_r;
    ptr_s   = ptr_r;
    cnt_s   = cnt_r;
    ign_s   = ign_r & {m1_lock, m0_lock};
    if (rst) begin
      gnt_s = 2'b00;
    end else begin
      case (state_r)
        ARB: begin
          if (m0_req && m1_req) begin
            gnt_s = (ptr_r == 1'b0) ? 2'b01 : 2'b10;
          end else begin
            gnt_s = {m1_req, m0_req};
          end
          if (gnt_s[0]) begin
            ptr_s = 1'b1;
            if (lk_s[0]) begin
              if (LOCK_MAX > 1) begin
                state_s = LOCK0;
                cnt_s   = CW'(1);
              end else begin
                ign_s[0] = 1'b1;
              end
            end else begin
              state_s = ARB;
            end
          end else if (gnt_s[1]) begin
            ptr_s = 1'b0;
            if (lk_s[1]) begin
              if (LOCK_MAX > 1) begin
                state_s = LOCK1;
                cnt_s   = CW'(1);
              end else begin
                ign_s[1] = 1'b1;
              end
            end else begin
              state_s = ARB;
            end
          end else begin
            state_s = ARB;
          end
        end
        LOCK0: begin
          gnt_s = {1'b0, m0_req};
          if (!m0_req || !m0_lock) begin
            state_s = ARB;
            ptr_s   = 1'b1;
            cnt_s   = m0_req ? cnt_inc_s : cnt_r;
          end else if (cnt_inc_s == CW'(LOCK_MAX)) begin
            state_s  = ARB;
            ptr_s    = 1'b1;
            cnt_s    = cnt_inc_s;
            ign_s[0] = 1'b1;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end
        LOCK1: begin
          gnt_s = {m1_req, 1'b0};
          if (!m1_req || !m1_lock) begin
            state_s = ARB;
            ptr_s   = 1'b0;
            cnt_s   = m1_req ? cnt_inc_s : cnt_r;
          end else if (cnt_inc_s == CW'(LOCK_MAX)) begin
            state_s  = ARB;
            ptr_s    = 1'b0;
            cnt_s    = cnt_inc_s;
            ign_s[1] = 1'b1;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end
        default: begin
          state_s = ARB;
          gnt_s   = 2'b00;
        end
      endcase
    end
  end

  assign m0_gnt    = gnt_s[0];
  assign m1_gnt    = gnt_s[1];
  assign mem_write = (gnt_s[0] & m0_we) | (gnt_s[1] & m1_we);
  assign mem_read  = (gnt_s[0] & ~m0_we) | (gnt_s[1] & ~m1_we);
  assign mem_addr  = gnt_s[0] ? m0_addr  : (gnt_s[1] ? m1_addr  : {AW{1'b0}});
  assign mem_wdata = gnt_s[0] ? m0_wdata : (gnt_s[1] ? m1_wdata : 32'd0);

  // FSM, round-robin pointer, lock counter and sticky-ignore flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ARB;
      ptr_r   <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      ign_r   <= 2'b00;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      cnt_r   <= cnt_s;
      ign_r   <= ign_s;
    end
  end

  // Load return path: capture read data at the grant edge, present it for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_r <= 2'b00;
      rdata0_r <= 32'd0;
      rdata1_r <= 32'd0;
    end else begin
      rvalid_r <= {gnt_s[1] & ~m1_we, gnt_s[0] & ~m0_we};
      if (gnt_s[0] && !m0_we) begin
        rdata0_r <= mem_rdata;
      end
      if (gnt_s[1] && !m1_we) begin
        rdata1_r <= mem_rdata;
      end
    end
  end

  assign m0_rvalid = rvalid_r[0];
  assign m1_rvalid = rvalid_r[1];
  assign m0_rdata  = rdata0_r;
  assign m1_rdata  = rdata1_r;

endmodule
